// File: rtl/conv_channel_sequencer_pkg.sv
// Shared types and constants for the convolution channel sequencer.
package conv_seq_pkg;

    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned DIM_W   = 8;
    localparam int unsigned CH_W    = 8;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned DRAIN_W = 2;
    localparam int unsigned WD_W    = 16;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CFG     = 3'd1;
    localparam logic [2:0] S_ARM     = 3'd2;
    localparam logic [2:0] S_FILL    = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_COMPUTE = 3'd5;
    localparam logic [2:0] S_NEXT    = 3'd6;
    localparam logic [2:0] S_FINISH  = 3'd7;

    // ROM read latency (1) plus the two-stage write-enable delay
    localparam logic [DRAIN_W-1:0] DRAIN_CYCLES = 2'd3;
    localparam logic [WD_W-1:0]    TIMEOUT_MAX  = 16'hFFFF;

    // Layer configuration captured when a start is accepted
    typedef struct packed {
        logic [CH_W-1:0]  num_channels;
        logic [DIM_W-1:0] weight_size;
        logic [DIM_W-1:0] height;
        logic [DIM_W-1:0] width;
    } layer_cfg_t;

    // True when the latched geometry cannot be processed
    function automatic logic cfg_illegal(input layer_cfg_t cfg);
        return (cfg.num_channels == '0) || (cfg.weight_size == '0) ||
               (cfg.weight_size > cfg.height) || (cfg.weight_size > cfg.width);
    endfunction

endpackage

// File: rtl/conv_channel_sequencer_if.sv
// Host/config and fill/array datapath signals of the channel sequencer.
interface conv_channel_sequencer_if;
    import conv_seq_pkg::*;

    logic                start;
    logic [ADDR_W-1:0]   base_address;
    logic [CH_W-1:0]     num_channels;
    logic [DIM_W-1:0]    weight_size;
    logic [DIM_W-1:0]    image_height;
    logic [DIM_W-1:0]    image_width;
    logic                fill_done;
    logic                array_done;
    logic                fill_enable;
    logic                fill_reset_n;
    logic [ADDR_W-1:0]   fill_address;
    logic [DIM_W-1:0]    fill_weight_size;
    logic [DIM_W-1:0]    fill_height;
    logic [DIM_W-1:0]    fill_width;
    logic                array_start;
    logic                busy;
    logic                done;
    logic                error;
    logic [CH_W-1:0]     channel_idx;
    logic [STATE_W-1:0]  state;

    modport slave (
        input  start, base_address, num_channels, weight_size, image_height,
               image_width, fill_done, array_done,
        output fill_enable, fill_reset_n, fill_address, fill_weight_size,
               fill_height, fill_width, array_start, busy, done, error,
               channel_idx, state
    );

    modport master (
        output start, base_address, num_channels, weight_size, image_height,
               image_width, fill_done, array_done,
        input  fill_enable, fill_reset_n, fill_address, fill_weight_size,
               fill_height, fill_width, array_start, busy, done, error,
               channel_idx, state
    );

endinterface

// File: rtl/conv_channel_sequencer_watchdog.sv
// Wait-state watchdog; only present when CONV_SEQ_TIMEOUT_EN is defined.
`ifdef CONV_SEQ_TIMEOUT_EN
module seq_watchdog
    import conv_seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired_c
);

    logic [WD_W-1:0] count_q;

    // Count while waiting; clearing when idle reloads it on every wait-state entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    count_q <= '0;
        else if (run) count_q <= count_q + WD_W'(1);
        else          count_q <= '0;
    end

    assign expired_c = run && (count_q == (TIMEOUT_MAX - WD_W'(1)));

endmodule
`endif

// File: rtl/conv_channel_sequencer.sv
// Per-channel fill/drain/compute sequencer for one convolution layer.
// Optional watchdog on FILL/COMPUTE: define CONV_SEQ_TIMEOUT_EN.
module conv_channel_sequencer
    import conv_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    conv_channel_sequencer_if.slave  bus
);

    logic [STATE_W-1:0]   state_q, state_d;
    layer_cfg_t           cfg_q, cfg_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W-1:0]    plane_q, plane_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 fill_en_q, fill_en_d;
    logic                 fill_rst_n_q, fill_rst_n_d;
    logic                 arr_start_q, arr_start_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic [2*DIM_W-1:0]   plane_c;
    logic                 wd_expired_c;

    assign plane_c = cfg_q.height * cfg_q.width;

`ifdef CONV_SEQ_TIMEOUT_EN
    logic wd_run_c;
    assign wd_run_c = (state_q == S_FILL) || (state_q == S_COMPUTE);
    seq_watchdog u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .run       (wd_run_c),
        .expired_c (wd_expired_c)
    );
`else
    assign wd_expired_c = 1'b0;
`endif

    // Next-state, datapath and next-output decode
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        addr_d  = addr_q;
        plane_d = plane_q;
        ch_d    = ch_q;
        drain_d = drain_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cfg_d   = '{num_channels: bus.num_channels, weight_size: bus.weight_size,
                                height: bus.image_height, width: bus.image_width};
                    err_d   = 1'b0;
                    ch_d    = '0;
                    addr_d  = bus.base_address;
                    state_d = S_CFG;
                end
            end
            S_CFG: begin
                if (cfg_illegal(cfg_q)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    plane_d = ADDR_W'(plane_c);
                    state_d = S_ARM;
                end
            end
            S_ARM: state_d = S_FILL;
            S_FILL: begin
                if (wd_expired_c) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.fill_done) begin
                    drain_d = DRAIN_CYCLES;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q - DRAIN_W'(1);
                if (drain_q == DRAIN_W'(1)) state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                // a done coinciding with our own start pulse belongs to nothing we issued
                if (wd_expired_c) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.array_done && !arr_start_q) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (ch_q == (cfg_q.num_channels - CH_W'(1))) begin
                    state_d = S_FINISH;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    addr_d  = addr_q + plane_q;
                    state_d = S_ARM;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        fill_en_d    = (state_d == S_FILL);
        fill_rst_n_d = (state_d != S_ARM);
        arr_start_d  = (state_q == S_DRAIN) && (state_d == S_COMPUTE);
        done_d       = (state_d == S_FINISH);
        busy_d       = (state_d != S_IDLE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cfg_q        <= '0;
            addr_q       <= '0;
            plane_q      <= '0;
            ch_q         <= '0;
            drain_q      <= '0;
            fill_en_q    <= 1'b0;
            fill_rst_n_q <= 1'b1;
            arr_start_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            addr_q       <= addr_d;
            plane_q      <= plane_d;
            ch_q         <= ch_d;
            drain_q      <= drain_d;
            fill_en_q    <= fill_en_d;
            fill_rst_n_q <= fill_rst_n_d;
            arr_start_q  <= arr_start_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.fill_enable      = fill_en_q;
    assign bus.fill_reset_n     = fill_rst_n_q;
    assign bus.fill_address     = addr_q;
    assign bus.fill_weight_size = cfg_q.weight_size;
    assign bus.fill_height      = cfg_q.height;
    assign bus.fill_width       = cfg_q.width;
    assign bus.array_start      = arr_start_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.error            = err_q;
    assign bus.channel_idx      = ch_q;
    assign bus.state            = state_q;

endmodule

// File: doc/conv_channel_sequencer.md
# conv_channel_sequencer

Top-level sequencer for one convolution layer. Walks the input image channel by channel. For each channel it re-arms and runs `fifo_fill_control` at the channel's base address, waits for the fill pipeline to drain, then starts the systolic array and waits for it to finish. It sits between the host/config registers and the fill/array datapath; it owns the fill controller's enable and active-low reset.

## Interface
- `ADDR_W`, 20, ROM address width (matches `initial_address`).
- `DIM_W`, 8, width of `weight_size`, `image_height` and `image_width`.
- `CH_W`, 8, width of the channel count.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `base_address` input ADDR_W: address of channel 0, pixel (0,0).
- `num_channels` input CH_W: channel count; 0 is illegal.
- `weight_size`, `image_height`, `image_width` input DIM_W each: layer geometry; latched at start.
- `fill_done` input 1: sticky done from the fill controller.
- `array_done` input 1: one-cycle done pulse from the array.
- `fill_enable` output 1: enable to the fill controller.
- `fill_reset_n` output 1: active-low re-arm pulse to the fill controller.
- `fill_address` output ADDR_W: `initial_address` for the current channel.
- `fill_weight_size`, `fill_height`, `fill_width` output DIM_W each: latched geometry.
- `array_start` output 1: one-cycle start pulse to the array.
- `busy` output 1: high in every state other than IDLE.
- `done` output 1: one-cycle pulse when the layer completes.
- `error` output 1: sticky config or timeout error; cleared only by `reset` or by an accepted `start`.
- `channel_idx` output CH_W: index of the current channel.
- `state` output 3: current state encoding, for debug.

## Operation
States and encodings: IDLE=0, CFG=1, ARM=2, FILL=3, DRAIN=4, COMPUTE=5, NEXT=6, FINISH=7.
- **IDLE**
  - On `start`: latch the config, clear `error`, set `channel_idx`=0, set `fill_address`=`base_address`, go to CFG.
- **CFG**
  - If `num_channels`==0, or `weight_size`==0, or `weight_size`>`image_height`, or `weight_size`>`image_width`: set `error`, go to IDLE. No `done` is issued.
  - Otherwise compute `plane` = `image_height`*`image_width` (2·DIM_W bits, zero-extended to ADDR_W), then go to ARM.
- **ARM**
  - Drive `fill_reset_n`=0 for exactly one cycle. This clears the fill controller's sticky `done`.
  - `fill_enable`=0 in this state. Go to FILL.
- **FILL**
  - Hold `fill_enable`=1 until `fill_done`=1.
  - Then deassert `fill_enable`, load the drain counter with `DRAIN_CYCLES`=3, go to DRAIN.
  - `DRAIN_CYCLES` covers the 1-cycle ROM latency plus the 2-stage write-enable delay.
- **DRAIN**
  - Decrement the counter each cycle. At 0, pulse `array_start` for one cycle and go to COMPUTE.
- **COMPUTE**
  - Wait for `array_done`, then go to NEXT.
  - If `array_done` arrives in the same cycle that `array_start` is issued, it is ignored.
- **NEXT**
  - If `channel_idx`==`num_channels`-1, go to FINISH.
  - Otherwise increment `channel_idx`, set `fill_address` += `plane` (mod 2^ADDR_W, wrap is silent), go to ARM.
- **FINISH**
  - Pulse `done` for one cycle, go to IDLE.
- `start` outside IDLE is ignored.
- Config inputs may change while `busy`; only the latched copies are used.

## Timing
Reset values: `state`=IDLE, `fill_enable`=0, `fill_reset_n`=1, `array_start`=0, `done`=0, `error`=0, `busy`=0, `channel_idx`=0, `fill_address`=0, geometry outputs=0.

Cycle numbering for a legal layer, with `start` sampled high at edge 0:
- Edge 1: enter CFG.
- Edge 2: enter ARM; `fill_reset_n` is low during cycle 2.
- Edge 3: enter FILL; `fill_enable` is high from cycle 3.
- `fill_done` seen at edge F: DRAIN covers edges F+1..F+3.
- `array_start` is high for the cycle after edge F+3.

Per-channel overhead beyond fill and compute: 7 cycles (ARM 1, FILL exit 1, DRAIN 3, NEXT 1, COMPUTE exit 1).

`done` rises 1 cycle after the last NEXT. `busy` falls in the same cycle `done` falls.

Reset mid-operation: all outputs return to their reset values asynchronously. `fill_reset_n` stays 1; the fill controller has its own reset.

## Configuration
- `CONV_SEQ_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts cycles spent in FILL or COMPUTE. It reloads on each state entry.
  - When it reaches 0xFFFF: set `error`, deassert `fill_enable`, go to IDLE without `done`.
- Undefined: no watchdog logic; FILL and COMPUTE wait indefinitely.

## Structure
- Package `conv_seq_pkg` holds:
  - the state encodings;
  - `DRAIN_CYCLES`=3;
  - `TIMEOUT_MAX`=16'hFFFF.
- One sub-module, `seq_watchdog` (counter, reload, expiry flag), instantiated only under `CONV_SEQ_TIMEOUT_EN`.

## Test plan
- Legal layer, base=0x00100, 8×8 image, weight 3, 3 channels; model returns `fill_done` after 50 cycles and `array_done` after 20.
  - Required: `fill_address` = 0x00100, 0x00140, 0x00180.
  - Required: three `fill_reset_n` low pulses and three `array_start` pulses, each exactly 4 cycles after its `fill_done`.
  - Required: `done` pulses once; `channel_idx` ends at 2.
- Illegal config: `weight_size`=9 with an 8×8 image → `error`=1 two cycles after `start`; no `fill_enable`; no `done`.
- `num_channels`=0 → `error`=1; a following legal `start` clears `error` and completes.
- Address wrap: base=0xFFFC0, 8×8 image, 2 channels → second `fill_address`=0x00000.
- `reset` asserted mid-FILL → all outputs return to reset values immediately; a later `start` runs normally.
- With `CONV_SEQ_TIMEOUT_EN`: `fill_done` never asserted → `error`=1 and `state`=IDLE 65535 cycles after FILL entry.
